mileage_ctrl: RTL and testbench
===============================

# mileage_ctrl

- Sequences the odometer of the car simulation.
- Converts movement time into distance units and queues them in a small pending counter.
- Applies each unit to the total and trip accumulators through one shared 4-digit BCD incrementer, time-shared by a three-state FSM.
- Sits between the car state machine (movement inputs, trip-clear button) and the seven-segment display driver, which shows `total_mile` / `trip_mile`.

## Interface
- `DIST_DIV`, 25: moving `clk_div` cycles per distance unit (≥1).
- `PEND_W`, 4: pending-counter width; PEND_MAX = 2^PEND_W − 1.
- `clk_div`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `move_forward`  in  1  car moving forward.
- `move_backward`  in  1  car moving backward.
- `trip_clear`  in  1  level; clear trip accumulator.
- `total_mile`  out  16  total distance, 4 BCD digits, reset 0x0000.
- `trip_mile`  out  16  trip distance, 4 BCD digits, reset 0x0000.
- `busy`  out  1  FSM not IDLE, reset 0.
- `total_wrap`  out  1  one-cycle pulse when total rolls 9999→0000, reset 0.
- `overflow`  out  1  sticky: a unit was dropped because pending was full; reset 0.

## Operation
- **moving**: exactly one of `move_forward` / `move_backward` is high. Both high or both low means not moving.
- **Prescaler `cnt`** (0..DIST_DIV−1):
  - Increments on moving cycles.
  - At DIST_DIV−1 with moving, returns to 0 and asserts internal `earn` for that cycle.
  - Holds its value (not cleared) while not moving.
- **Pending counter `pend`**:
  - `+1` on earn.
  - `−1` in every INC_TOTAL cycle.
  - Both in the same cycle: unchanged.
  - Earn while pend == PEND_MAX and no decrement: unit dropped, `overflow` ← 1 (sticky until reset).
- **FSM**:
  - IDLE → INC_TOTAL when pend ≠ 0.
  - INC_TOTAL: `total_mile` ← inc(`total_mile`), then → INC_TRIP.
  - INC_TRIP: `trip_mile` ← inc(`trip_mile`), then → INC_TOTAL if pend ≠ 0 (value after this cycle's update), else IDLE.
- **Shared incrementer**:
  - Operand mux selects `total_mile` in INC_TOTAL and `trip_mile` otherwise.
  - Digit-wise BCD +1 with decimal carry.
  - 9999 + 1 = 0000 with carry-out; no binary intermediate.
- **Wrap rules**:
  - `total_mile` wraps 9999→0000 and sets `total_wrap` for exactly one cycle, the cycle in which 0000 is visible.
  - `trip_mile` wraps silently.
- **`trip_clear`** high: `trip_mile` ← 0000 every cycle.
  - Clear wins over a simultaneous INC_TRIP; that unit is still counted in the total.
  - The FSM and `pend` are unaffected.
- **`reset`** mid-sequence: all state returns to reset values, state ← IDLE, queued units discarded.

## Timing
- All registers update on posedge `clk_div`; all outputs are registered.
- Latency from earn cycle N:
  - `total_mile` updates at the end of N+2 (IDLE sees pend ≠ 0 in N+1, INC_TOTAL in N+2).
  - `trip_mile` updates at the end of N+3.
- Throughput: one unit per 2 cycles. With DIST_DIV = 1 under continuous motion, pend grows by 1 every 2 cycles until full, then `overflow` sets.
- `busy` = (state ≠ IDLE), registered with the state.

## Configuration
- `MILEAGE_TRIP_EN` defined:
  - Trip accumulator, `trip_clear` handling and the INC_TRIP state are present as described.
- `MILEAGE_TRIP_EN` not defined:
  - No trip register; `trip_mile` tied to 0x0000 and `trip_clear` ignored.
  - FSM is IDLE/INC_TOTAL only: INC_TOTAL → INC_TOTAL if pend ≠ 0 after its decrement, else IDLE.
  - Throughput becomes one unit per cycle.
- The port list is identical in both builds.

## Structure
- **Shared package `car_pkg`**:
  - FSM state enum `mile_state_t` {IDLE, INC_TOTAL, INC_TRIP}.
  - `BCD_MAX4` = 16'h9999.
  - Default `DIST_DIV`.
- **Sub-module `bcd_inc4`**:
  - Purely combinational: 16-bit BCD in → 16-bit BCD out plus carry-out.
  - Instantiated once and fed by the operand mux.

## Test plan
- DIST_DIV = 3; reset, then `move_forward` for 9 cycles → three earns; `total_mile` 0x0003, `trip_mile` 0x0003, `overflow` 0.
- Movement paused mid-unit: forward 2 cycles, idle 5, forward 1 → exactly one unit; both fwd+bwd high for 10 cycles → no units.
- Preload total to 0x9999 by driving 9999 units (DIST_DIV = 1, long run with pauses so pend never saturates) → next unit gives `total_mile` 0x0000 with a one-cycle `total_wrap`; `trip_mile` likewise 0x0000 with no pulse.
- `trip_clear` held during an INC_TRIP cycle → `trip_mile` 0x0000, `total_mile` still incremented.
- DIST_DIV = 1, PEND_W = 2, forward for 20 cycles → `overflow` set and stays set; after motion stops, `busy` falls once pend drains.
- `reset` asserted while `busy` with pend = 2 → next cycle all outputs 0, state IDLE, no further increments.

Source files
------------

// File: rtl/car_pkg.sv
// Shared odometer types and constants for the car simulation.
package car_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    INC_TOTAL = 2'd1,
    INC_TRIP  = 2'd2
  } mile_state_t;

  localparam logic [15:0] BCD_MAX4     = 16'h9999;
  localparam int          DIST_DIV_DEF = 25;

endpackage

// File: rtl/mileage_ctrl_if.sv
// Odometer bus between the car state machine (master) and mileage_ctrl (slave).
interface mileage_ctrl_if;
  import car_pkg::*;

  // No handshake: movement/clear are levels sampled every clk_div edge, and
  // every output is a registered level (total_wrap is a one-cycle pulse).
  logic        move_forward;
  logic        move_backward;
  logic        trip_clear;
  logic [15:0] total_mile;
  logic [15:0] trip_mile;
  logic        busy;
  logic        total_wrap;
  logic        overflow;
  mile_state_t state;

  modport master (
    output move_forward, move_backward, trip_clear,
    input  total_mile, trip_mile, busy, total_wrap, overflow, state
  );

  modport slave (
    input  move_forward, move_backward, trip_clear,
    output total_mile, trip_mile, busy, total_wrap, overflow, state
  );

endinterface

// File: rtl/mileage_ctrl_bcd_inc4.sv
// Combinational 4-digit BCD +1 with decimal carry; 9999 + 1 = 0000, carry 1.
module bcd_inc4
  import car_pkg::*;
(
  input  logic [15:0] din,
  output logic [15:0] dout,
  output logic        carry
);

  logic c;

  always_comb begin
    dout = 16'h0000;
    c    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c && din[i*4 +: 4] == 4'd9) begin
        dout[i*4 +: 4] = 4'd0;
      end else if (c) begin
        dout[i*4 +: 4] = din[i*4 +: 4] + 4'd1;
        c = 1'b0;
      end else begin
        dout[i*4 +: 4] = din[i*4 +: 4];
      end
    end
    carry = (din == BCD_MAX4);
  end

endmodule

// File: rtl/mileage_ctrl.sv
// Odometer sequencer: prescaler, pending-unit counter and a shared BCD incrementer.
// Trip accumulator and INC_TRIP state exist only when MILEAGE_TRIP_EN is defined.
module mileage_ctrl
  import car_pkg::*;
#(
  parameter int DIST_DIV = DIST_DIV_DEF,
  parameter int PEND_W   = 4
) (
  input  logic           clk_div,
  input  logic           reset,
  mileage_ctrl_if.slave  bus
);

  localparam int                CNT_W    = (DIST_DIV > 1) ? $clog2(DIST_DIV) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DIST_DIV - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};

  logic [CNT_W-1:0]  cnt;
  logic [PEND_W-1:0] pend, pend_next;
  mile_state_t       state, state_next;
  logic [15:0]       total, trip, inc_in, inc_out;
  logic              inc_carry, moving, earn, dec, drop, wrap_q, ovf_q;

  always_comb begin
    moving    = bus.move_forward ^ bus.move_backward;
    earn      = moving && (cnt == CNT_LAST);
    dec       = (state == INC_TOTAL);
    pend_next = pend;
    drop      = 1'b0;
    if (earn && !dec) begin
      if (pend == PEND_MAX) drop = 1'b1;
      else                  pend_next = pend + 1'b1;
    end else if (!earn && dec) begin
      pend_next = pend - 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (pend != '0) state_next = INC_TOTAL;
`ifdef MILEAGE_TRIP_EN
      INC_TOTAL: state_next = INC_TRIP;
      INC_TRIP:  state_next = (pend_next != '0) ? INC_TOTAL : IDLE;
`else
      INC_TOTAL: state_next = (pend_next != '0) ? INC_TOTAL : IDLE;
`endif
      default:   state_next = IDLE;
    endcase
  end

  assign inc_in = (state == INC_TOTAL) ? total : trip;

  bcd_inc4 u_inc (
    .din   (inc_in),
    .dout  (inc_out),
    .carry (inc_carry)
  );

  always_ff @(posedge clk_div) begin
    if (reset) begin
      cnt    <= '0;
      pend   <= '0;
      state  <= IDLE;
      total  <= 16'h0000;
      wrap_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      if (moving) cnt <= earn ? '0 : cnt + 1'b1;
      pend   <= pend_next;
      state  <= state_next;
      if (dec) total <= inc_out;
      wrap_q <= dec && inc_carry;
      if (drop) ovf_q <= 1'b1;
    end
  end

`ifdef MILEAGE_TRIP_EN
  // Clear has priority over a same-cycle INC_TRIP; the unit still reached total.
  always_ff @(posedge clk_div) begin
    if (reset)                 trip <= 16'h0000;
    else if (bus.trip_clear)   trip <= 16'h0000;
    else if (state == INC_TRIP) trip <= inc_out;
  end
`else
  logic unused_trip_clear;
  assign unused_trip_clear = bus.trip_clear;
  assign trip              = 16'h0000;
`endif

  assign bus.total_mile = total;
  assign bus.trip_mile  = trip;
  assign bus.busy       = (state != IDLE);
  assign bus.total_wrap = wrap_q;
  assign bus.overflow   = ovf_q;
  assign bus.state      = state;

endmodule

// File: tb/tb_mileage_ctrl.sv
// Bench for mileage_ctrl: two configurations (DIST_DIV=3/PEND_W=4, DIST_DIV=1/PEND_W=2)
// checked each cycle against an integer-arithmetic model, plus literal expectations.
module tb_mileage_ctrl;
  import car_pkg::*;

  logic clk_div = 1'b0;
  always #5 clk_div = ~clk_div;

  logic ra, rb;
  logic cmp_en = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   wrap_cnt_b = 0;

  mileage_ctrl_if ia ();
  mileage_ctrl_if ib ();

  mileage_ctrl #(.DIST_DIV(3), .PEND_W(4)) dut_a (.clk_div(clk_div), .reset(ra), .bus(ia.slave));
  mileage_ctrl #(.DIST_DIV(1), .PEND_W(2)) dut_b (.clk_div(clk_div), .reset(rb), .bus(ib.slave));

  // Model state: unit counts as plain integers, service phase 0=idle 1=total 2=trip
  int m_cnt[2], m_pend[2], m_phase[2], m_total[2], m_trip[2];
  bit m_wrap[2], m_ovf[2];

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input int k, input logic rst, input logic f, input logic b,
                            input logic c);
    int  div, pmax, np;
    bit  earn, svc_t, svc_r;
    div  = (k == 0) ? 3 : 1;
    pmax = (k == 0) ? 15 : 3;
    if (rst) begin
      m_cnt[k] = 0; m_pend[k] = 0; m_phase[k] = 0; m_total[k] = 0; m_trip[k] = 0;
      m_wrap[k] = 0; m_ovf[k] = 0;
      return;
    end
    earn = 0;
    if (f != b) begin
      if (m_cnt[k] == div - 1) begin m_cnt[k] = 0; earn = 1; end
      else m_cnt[k]++;
    end
    svc_t = (m_phase[k] == 1);
    svc_r = (m_phase[k] == 2);
    np = m_pend[k] - (svc_t ? 1 : 0);
    if (earn) begin
      if (np == pmax) m_ovf[k] = 1;
      else np++;
    end
    m_wrap[k] = svc_t && (m_total[k] == 9999);
    if (svc_t) m_total[k] = (m_total[k] + 1) % 10000;
`ifdef MILEAGE_TRIP_EN
    if (c) m_trip[k] = 0;
    else if (svc_r) m_trip[k] = (m_trip[k] + 1) % 10000;
    if (m_phase[k] == 0)      m_phase[k] = (m_pend[k] != 0) ? 1 : 0;
    else if (m_phase[k] == 1) m_phase[k] = 2;
    else                      m_phase[k] = (np != 0) ? 1 : 0;
`else
    if (c && svc_r) m_trip[k] = 0;
    if (m_phase[k] == 0) m_phase[k] = (m_pend[k] != 0) ? 1 : 0;
    else                 m_phase[k] = (np != 0) ? 1 : 0;
`endif
    m_pend[k] = np;
  endtask

  always @(posedge clk_div) begin
    model_step(0, ra, ia.move_forward, ia.move_backward, ia.trip_clear);
    model_step(1, rb, ib.move_forward, ib.move_backward, ib.trip_clear);
  end

  always @(negedge clk_div) begin
    if (cmp_en) begin
      check("a_total", ia.total_mile, to_bcd(m_total[0]));
      check("a_trip",  ia.trip_mile,  to_bcd(m_trip[0]));
      check("a_busy",  16'(ia.busy),  16'(m_phase[0] != 0));
      check("a_wrap",  16'(ia.total_wrap), 16'(m_wrap[0]));
      check("a_ovf",   16'(ia.overflow),   16'(m_ovf[0]));
      check("b_total", ib.total_mile, to_bcd(m_total[1]));
      check("b_trip",  ib.trip_mile,  to_bcd(m_trip[1]));
      check("b_busy",  16'(ib.busy),  16'(m_phase[1] != 0));
      check("b_wrap",  16'(ib.total_wrap), 16'(m_wrap[1]));
      check("b_ovf",   16'(ib.overflow),   16'(m_ovf[1]));
      if (ib.total_wrap) wrap_cnt_b++;
    end
  end

  task automatic drive_a(input logic f, input logic b, input logic c, input int n);
    ia.move_forward = f; ia.move_backward = b; ia.trip_clear = c;
    repeat (n) begin @(posedge clk_div); #1; end
  endtask

  task automatic drive_b(input logic f, input logic b, input logic c, input int n);
    ib.move_forward = f; ib.move_backward = b; ib.trip_clear = c;
    repeat (n) begin @(posedge clk_div); #1; end
  endtask

  task automatic reset_b();
    rb = 1'b1;
    drive_b(0, 0, 0, 1);
    rb = 1'b0;
  endtask

  task automatic wait_idle_b(input int limit);
    int n = 0;
    while (ib.busy && n < limit) begin @(posedge clk_div); #1; n++; end
    check("b_drain_timeout", 16'(ib.busy), 16'h0000);
  endtask

  localparam logic [15:0] TRIP3 =
`ifdef MILEAGE_TRIP_EN
    16'h0003;
`else
    16'h0000;
`endif
  localparam logic [15:0] TRIP9999 =
`ifdef MILEAGE_TRIP_EN
    16'h9999;
`else
    16'h0000;
`endif
  localparam logic [15:0] OVF_EXP =
`ifdef MILEAGE_TRIP_EN
    16'h0001;
`else
    16'h0000;
`endif

  initial begin
    ra = 1'b1; rb = 1'b1;
    ia.move_forward = 0; ia.move_backward = 0; ia.trip_clear = 0;
    ib.move_forward = 0; ib.move_backward = 0; ib.trip_clear = 0;
    repeat (2) begin @(posedge clk_div); #1; end
    check("a_reset_total", ia.total_mile, 16'h0000);
    check("a_reset_busy",  16'(ia.busy), 16'h0000);
    ra = 1'b0; rb = 1'b0;
    cmp_en = 1'b1;

    // Three units from nine forward cycles
    drive_a(1, 0, 0, 9);
    drive_a(0, 0, 0, 10);
    check("t1_total", ia.total_mile, 16'h0003);
    check("t1_trip",  ia.trip_mile,  TRIP3);
    check("t1_ovf",   16'(ia.overflow), 16'h0000);

    // Prescaler holds across a pause; fwd+bwd together is not motion
    drive_a(1, 0, 0, 2);
    drive_a(0, 0, 0, 5);
    drive_a(1, 0, 0, 1);
    drive_a(0, 0, 0, 8);
    check("t2_pause_total", ia.total_mile, 16'h0004);
    drive_a(1, 1, 0, 10);
    drive_a(0, 0, 0, 6);
    check("t2_both_total", ia.total_mile, 16'h0004);

    // Trip clear held across the INC_TRIP of the next unit
    drive_a(1, 0, 0, 2);
    drive_a(1, 0, 1, 1);
    drive_a(0, 0, 1, 6);
    drive_a(0, 0, 0, 2);
    check("t4_total", ia.total_mile, 16'h0005);
    check("t4_trip",  ia.trip_mile,  16'h0000);

    repeat (400) begin
      drive_a(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 15) == 0), $urandom_range(1, 4));
    end
    drive_a(0, 0, 0, 4);

    // Preload total to 9999 one unit every two cycles, then wrap
    reset_b();
    repeat (9999) begin
      drive_b(1, 0, 0, 1);
      drive_b(0, 0, 0, 1);
    end
    drive_b(0, 0, 0, 4);
    check("t3_total_9999", ib.total_mile, 16'h9999);
    check("t3_trip_9999",  ib.trip_mile,  TRIP9999);
    check("t3_no_wrap_yet", 16'(wrap_cnt_b), 16'h0000);
    drive_b(1, 0, 0, 1);
    drive_b(0, 0, 0, 5);
    check("t3_total_wrap", ib.total_mile, 16'h0000);
    check("t3_trip_wrap",  ib.trip_mile,  16'h0000);
    check("t3_wrap_pulses", 16'(wrap_cnt_b), 16'h0001);

    // Continuous motion saturates a 2-bit pending counter
    reset_b();
    drive_b(1, 0, 0, 20);
    drive_b(0, 0, 0, 1);
    wait_idle_b(60);
    check("t5_ovf", 16'(ib.overflow), OVF_EXP);
    drive_b(0, 0, 0, 5);
    check("t5_ovf_sticky", 16'(ib.overflow), OVF_EXP);

    // Reset while busy with units queued
    reset_b();
    drive_b(1, 0, 0, 3);
    rb = 1'b1;
    drive_b(0, 0, 0, 1);
    rb = 1'b0;
    check("t6_total", ib.total_mile, 16'h0000);
    check("t6_busy",  16'(ib.busy),  16'h0000);
    check("t6_ovf",   16'(ib.overflow), 16'h0000);
    drive_b(0, 0, 0, 6);
    check("t6_total_after", ib.total_mile, 16'h0000);

    repeat (300) begin
      drive_b(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 7) == 0), $urandom_range(1, 6));
    end
    drive_b(0, 0, 0, 10);

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
